// File: rtl/sl_arb_pkg.sv
// sl_arb_pkg
//   Shared definitions for the slave-bus round-robin arbiter:
//     arb_state_t  arbiter FSM states (IDLE=0, GRANT=1, RELEASE=2)
//     clog2()      ceiling log2, for instantiators sizing IDX_W and TO_W
package sl_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Ceiling log2 with a floor of 1, so a width derived from it is never zero.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sl_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Returns the first set bit of
//   eligible at or after ptr, scanning upward and wrapping at NUM_REQ.
//   Ports:
//     eligible  in   NUM_REQ  candidate request vector
//     ptr       in   IDX_W    search start index (always < NUM_REQ)
//     found     out  1        at least one eligible bit is set
//     idx       out  IDX_W    picked index, 0 when nothing is found
module rr_pick
  import sl_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int cand;

  // Walk the offsets from farthest to nearest so the nearest eligible
  // candidate is the last one written and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (eligible[IDX_W'(cand)]) begin
        found = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sl_arbiter.sv
// sl_arbiter
//   Round-robin owner selection for the shared tri-state slave output bus
//   (sl_data, sl_tail, sl_addr). One-hot grants, a one-cycle all-zero
//   turnaround between owners, and a data-latch watchdog that revokes a
//   stalled owner and locks it out until it drops its request.
//   Ports:
//     clk             in   1        system clock
//     resetn          in   1        synchronous, active-low reset
//     sl_arb_request  in   NUM_REQ  one request bit per bus_interface
//     sl_data_latch   in   1        data-latch strobe, feeds the watchdog
//     sl_arb_grant    out  NUM_REQ  one-hot grant (registered)
//     grant_valid     out  1        OR of sl_arb_grant (registered)
//     grant_id        out  IDX_W    current owner, 0 when no grant
//     timeout_pulse   out  1        one-cycle pulse on revocation
//     timeout_id      out  IDX_W    last revoked owner, held
module sl_arbiter
  import sl_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] sl_arb_request,
  input  logic               sl_data_latch,
  output logic [NUM_REQ-1:0] sl_arb_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_id,
  output logic               timeout_pulse,
  output logic [IDX_W-1:0]   timeout_id
);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] lockout_q, lockout_d, lock_set;
  logic [TO_W-1:0]    wd_q, wd_d, wd_inc;

  logic [NUM_REQ-1:0] grant_d;
  logic               valid_d;
  logic [IDX_W-1:0]   id_d;
  logic               pulse_d;
  logic [IDX_W-1:0]   tid_d;

  logic [NUM_REQ-1:0] eligible;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               owner_req;
  logic               expire;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] id);
    return (int'(id) == NUM_REQ - 1) ? '0 : id + IDX_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

  assign eligible = sl_arb_request & ~lockout_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (rr_ptr_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // grant_id doubles as the owner register: it is only consulted in GRANT,
  // where it always holds the owner's index.
  assign owner_req = sl_arb_request[grant_id];

  // Watchdog saturates at TIMEOUT so it can never wrap back to a safe value.
  assign wd_inc = (wd_q == TO_W'(TIMEOUT)) ? wd_q : wd_q + TO_W'(1);
  assign expire = !sl_data_latch && (wd_inc == TO_W'(TIMEOUT));

  // A lockout bit survives only while its requester keeps requesting.
  assign lockout_d = (lockout_q & sl_arb_request) | lock_set;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    lock_set = '0;
    wd_d     = '0;
    grant_d  = '0;
    valid_d  = 1'b0;
    id_d     = '0;
    pulse_d  = 1'b0;
    tid_d    = timeout_id;

    case (state_q)
      GRANT: begin
        wd_d = sl_data_latch ? '0 : wd_inc;
        // A request drop takes priority over a simultaneous expiry.
        if (!owner_req) begin
          state_d  = RELEASE;
          rr_ptr_d = next_ptr(grant_id);
        end else if (expire) begin
          state_d            = RELEASE;
          rr_ptr_d           = next_ptr(grant_id);
          pulse_d            = 1'b1;
          tid_d              = grant_id;
          lock_set[grant_id] = 1'b1;
        end else begin
          grant_d = onehot(grant_id);
          valid_d = 1'b1;
          id_d    = grant_id;
        end
      end

      // IDLE and RELEASE arbitrate identically; RELEASE's all-zero output
      // cycle is the turnaround, so a new owner appears one edge later.
      default: begin
        if (pick_found) begin
          state_d = GRANT;
          grant_d = onehot(pick_idx);
          valid_d = 1'b1;
          id_d    = pick_idx;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Registered state and outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      lockout_q     <= '0;
      wd_q          <= '0;
      sl_arb_grant  <= '0;
      grant_valid   <= 1'b0;
      grant_id      <= '0;
      timeout_pulse <= 1'b0;
      timeout_id    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      lockout_q     <= lockout_d;
      wd_q          <= wd_d;
      sl_arb_grant  <= grant_d;
      grant_valid   <= valid_d;
      grant_id      <= id_d;
      timeout_pulse <= pulse_d;
      timeout_id    <= tid_d;
    end
  end

  a_grant_onehot : assert property (@(posedge clk) disable iff (!resetn)
    $onehot0(sl_arb_grant));

  a_valid_matches : assert property (@(posedge clk) disable iff (!resetn)
    grant_valid == (|sl_arb_grant));

  a_turnaround : assert property (@(posedge clk) disable iff (!resetn)
    ((sl_arb_grant != '0) && ($past(sl_arb_grant) != '0))
      |-> (sl_arb_grant == $past(sl_arb_grant)));

endmodule

// File: tb/tb_sl_arbiter.sv
module tb_sl_arbiter;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int TIMEOUT = 8;
  localparam int TO_W    = 4;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic [NUM_REQ-1:0] req = '0;
  logic               latch = 1'b0;
  logic [NUM_REQ-1:0] sl_arb_grant;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_id;
  logic               timeout_pulse;
  logic [IDX_W-1:0]   timeout_id;

  always #5 clk = ~clk;

  sl_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .sl_arb_request (req),
    .sl_data_latch  (latch),
    .sl_arb_grant   (sl_arb_grant),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .timeout_pulse  (timeout_pulse),
    .timeout_id     (timeout_id)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how long since the last sign of
  // activity, where the next search starts, and who is locked out.
  int  m_owner = -1;
  int  m_ptr   = 0;
  int  m_quiet = 0;
  int  m_tid   = 0;
  bit  m_pulse = 1'b0;
  bit  m_lock [NUM_REQ];
  bit  m_ready = 1'b0;

  always @(posedge clk) begin
    bit newlock [NUM_REQ];
    int c;
    m_pulse = 1'b0;
    if (!resetn) begin
      m_owner = -1;
      m_ptr   = 0;
      m_quiet = 0;
      m_tid   = 0;
      for (int i = 0; i < NUM_REQ; i++) m_lock[i] = 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) newlock[i] = m_lock[i] && req[i];
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_ptr   = (m_owner + 1) % NUM_REQ;
          m_owner = -1;
        end else begin
          m_quiet = latch ? 0 : m_quiet + 1;
          if (m_quiet == TIMEOUT) begin
            m_pulse          = 1'b1;
            m_tid            = m_owner;
            newlock[m_owner] = 1'b1;
            m_ptr            = (m_owner + 1) % NUM_REQ;
            m_owner          = -1;
          end
        end
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          c = (m_ptr + k) % NUM_REQ;
          if (req[c] && !m_lock[c]) begin
            m_owner = c;
            m_quiet = 0;
            break;
          end
        end
      end
      for (int i = 0; i < NUM_REQ; i++) m_lock[i] = newlock[i];
    end
    m_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ready) begin
      check("grant",   32'(sl_arb_grant),  (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("valid",   32'(grant_valid),   (m_owner >= 0) ? 32'd1 : 32'd0);
      check("id",      32'(grant_id),      (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check("pulse",   32'(timeout_pulse), 32'(m_pulse));
      check("to_id",   32'(timeout_id),    32'(m_tid));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req    = '0;
    latch  = 1'b0;
    tick(2);
    resetn = 1'b1;
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [NUM_REQ-1:0] e;
    int o;

    // Reset state, single request, release to IDLE
    do_reset();
    check("rst_grant", 32'(sl_arb_grant), 32'd0);
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_id", 32'(grant_id), 32'd0);
    check("rst_pulse", 32'(timeout_pulse), 32'd0);
    check("rst_to_id", 32'(timeout_id), 32'd0);
    req = 4'b0001;
    tick();
    check("req0_grant", 32'(sl_arb_grant), 32'h1);
    check("req0_id", 32'(grant_id), 32'd0);
    check("req0_valid", 32'(grant_valid), 32'd1);
    req = 4'b0000;
    tick();
    check("rel_grant", 32'(sl_arb_grant), 32'd0);
    tick();
    check("idle_grant", 32'(sl_arb_grant), 32'd0);

    // Round robin with all four requesting
    do_reset();
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      o = order[n];
      e = NUM_REQ'(1) << o;
      check("rr_owner", 32'(sl_arb_grant), 32'(e));
      check("rr_id", 32'(grant_id), 32'(o));
      tick(5);
      check("rr_hold", 32'(sl_arb_grant), 32'(e));
      req[o] = 1'b0;
      tick();
      check("rr_gap", 32'(sl_arb_grant), 32'd0);
      req[o] = 1'b1;
      tick();
    end

    // Watchdog revocation and lockout
    do_reset();
    req = 4'b0100;
    tick();
    check("to_grant", 32'(sl_arb_grant), 32'h4);
    check("model_owner", 32'(m_owner), 32'd2);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      if (i == TIMEOUT - 1) begin
        check("to_pre_grant", 32'(sl_arb_grant), 32'h4);
        check("to_pre_pulse", 32'(timeout_pulse), 32'd0);
      end
    end
    check("to_pulse", 32'(timeout_pulse), 32'd1);
    check("to_id_lit", 32'(timeout_id), 32'd2);
    check("to_revoked", 32'(sl_arb_grant), 32'd0);
    tick();
    check("to_pulse_end", 32'(timeout_pulse), 32'd0);
    tick(4);
    check("to_locked", 32'(sl_arb_grant), 32'd0);
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    check("to_regrant", 32'(sl_arb_grant), 32'h4);
    check("to_id_held", 32'(timeout_id), 32'd2);

    // Periodic data latch keeps the watchdog from firing
    do_reset();
    req = 4'b0100;
    tick();
    for (int c = 0; c < 100; c++) begin
      latch = (c % 6 == 5);
      tick();
      check("latch_nopulse", 32'(timeout_pulse), 32'd0);
      check("latch_hold", 32'(sl_arb_grant), 32'h4);
    end
    latch = 1'b0;

    // Drop and expiry on the same edge: the drop wins
    do_reset();
    req = 4'b0010;
    tick();
    tick(TIMEOUT - 1);
    check("tie_pre", 32'(sl_arb_grant), 32'h2);
    req = 4'b0000;
    tick();
    check("tie_pulse", 32'(timeout_pulse), 32'd0);
    check("tie_grant", 32'(sl_arb_grant), 32'd0);
    check("tie_to_id", 32'(timeout_id), 32'd0);
    req = 4'b0010;
    tick();
    check("tie_regrant", 32'(sl_arb_grant), 32'h2);

    // Reset in the middle of a grant
    req = 4'b1111;
    tick(3);
    resetn = 1'b0;
    req    = 4'b1010;
    tick();
    check("mid_rst_grant", 32'(sl_arb_grant), 32'd0);
    check("mid_rst_valid", 32'(grant_valid), 32'd0);
    check("mid_rst_id", 32'(grant_id), 32'd0);
    resetn = 1'b1;
    tick();
    check("post_rst_grant", 32'(sl_arb_grant), 32'h2);
    check("post_rst_id", 32'(grant_id), 32'd1);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NUM_REQ; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      latch  = ($urandom_range(0, 9) == 0);
      resetn = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
